cv32e40p_ft_tmr_monitor: RTL and testbench

Parametrised TMR voter with per-replica breakage monitors, for the fault-tolerant front end (aligner, compressed decoder). It votes NUM_CH output channels of three replicas bitwise. Each replica has a saturating leaky-bucket error counter; a replica that reaches threshold is declared broken and excluded from voting. With two replicas left the block runs as duplex compare; with one left it runs as simplex pass-through. A per-channel triplication mask selects which channels are voted.

---
 rtl/cv32e40p_ft_pkg.sv | 17 +
 rtl/cv32e40p_ft_breakage_counter.sv | 82 ++++++++
 rtl/cv32e40p_ft_tmr_monitor.sv | 121 ++++++++++++
 tb/tb_cv32e40p_ft_tmr_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and default tuning for the fault-tolerant
// TMR monitor and its per-replica breakage counters.
package cv32e40p_ft_pkg;

  typedef enum logic [1:0] {
    FT_HEALTHY,
    FT_SUSPECT,
    FT_BROKEN
  } ft_state_e;

  localparam int unsigned FT_COUNT_BIT          = 8;
  localparam int unsigned FT_INC_DEC_BIT        = 2;
  localparam int unsigned FT_INCREMENT          = 1;
  localparam int unsigned FT_DECREMENT          = 1;
  localparam int unsigned FT_BREAKING_THRESHOLD = 3;

endpackage

// File: rtl/cv32e40p_ft_breakage_counter.sv
// Saturating leaky-bucket error counter for one replica
// with a sticky broken flag.
module cv32e40p_ft_breakage_counter
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned COUNT_BIT          = FT_COUNT_BIT,
  parameter int unsigned INC_DEC_BIT        = FT_INC_DEC_BIT,
  parameter int unsigned INCREMENT          = FT_INCREMENT,
  parameter int unsigned DECREMENT          = FT_DECREMENT,
  parameter int unsigned BREAKING_THRESHOLD = FT_BREAKING_THRESHOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 err,
  input  logic                 clear,
  input  logic                 freeze,
  output logic [COUNT_BIT-1:0] count,
  output logic                 suspect,
  output logic                 broken
);

  localparam logic [INC_DEC_BIT-1:0] INC_V =
    INC_DEC_BIT'(INCREMENT);
  localparam logic [INC_DEC_BIT-1:0] DEC_V =
    INC_DEC_BIT'(DECREMENT);
  localparam logic [COUNT_BIT:0] INC_W =
    (COUNT_BIT+1)'(INC_V);
  localparam logic [COUNT_BIT:0] DEC_W =
    (COUNT_BIT+1)'(DEC_V);
  localparam logic [COUNT_BIT:0] THR_W =
    (COUNT_BIT+1)'(BREAKING_THRESHOLD);
  localparam logic [COUNT_BIT:0] CNT_MAX =
    {1'b0, {COUNT_BIT{1'b1}}};

  logic [COUNT_BIT-1:0] count_q, count_d;
  logic                 broken_q, broken_d;
  logic [COUNT_BIT:0]   ext, sum;
  ft_state_e            state;

  // One extra bit of headroom so saturation is seen, never a wrap
  always_comb begin
    ext      = {1'b0, count_q};
    sum      = ext;
    count_d  = count_q;
    broken_d = broken_q;
    if (err) begin
      sum = ext + INC_W;
      if (sum > CNT_MAX) sum = CNT_MAX;
    end else begin
      sum = (ext >= DEC_W) ? ext - DEC_W : '0;
    end
    if (clear) begin
      count_d  = '0;
      broken_d = 1'b0;
    end else if (en && !freeze && !broken_q) begin
      count_d  = sum[COUNT_BIT-1:0];
      broken_d = (sum >= THR_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      broken_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      broken_q <= broken_d;
    end
  end

  always_comb begin
    state = FT_HEALTHY;
    if (broken_q)            state = FT_BROKEN;
    else if (count_q != '0)  state = FT_SUSPECT;
  end

  assign count   = count_q;
  assign suspect = (state == FT_SUSPECT);
  assign broken  = (state == FT_BROKEN);

endmodule

// File: rtl/cv32e40p_ft_tmr_monitor.sv
// Bitwise TMR voter that degrades to duplex compare and
// simplex pass-through as replicas are declared broken.
module cv32e40p_ft_tmr_monitor
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned       NUM_CH   = 3,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [NUM_CH-1:0] TMR_MASK = {NUM_CH{1'b1}},
  parameter int unsigned COUNT_BIT          = FT_COUNT_BIT,
  parameter int unsigned INC_DEC_BIT        = FT_INC_DEC_BIT,
  parameter int unsigned INCREMENT          = FT_INCREMENT,
  parameter int unsigned DECREMENT          = FT_DECREMENT,
  parameter int unsigned BREAKING_THRESHOLD = FT_BREAKING_THRESHOLD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic [NUM_CH*DATA_W-1:0] rep0_i,
  input  logic [NUM_CH*DATA_W-1:0] rep1_i,
  input  logic [NUM_CH*DATA_W-1:0] rep2_i,
  output logic [NUM_CH*DATA_W-1:0] voted_o,
  output logic [NUM_CH-1:0]        err_ch_o,
  output logic                     uncorrectable_o,
  output logic [2:0]               suspect_o,
  output logic [2:0]               broken_o,
  output logic                     fatal_o,
  output logic [3*COUNT_BIT-1:0]   counts_o
);

  logic [2:0]        broken_q, healthy, rep_err;
  logic              tmr_mode, dup_mode, simp_mode;
  logic [NUM_CH-1:0] err0, err1, err2, mis;

  assign healthy = ~broken_q;

  always_comb begin
    tmr_mode  = &healthy;
    dup_mode  = (healthy == 3'b011) ||
                (healthy == 3'b101) ||
                (healthy == 3'b110);
    simp_mode = (healthy == 3'b001) ||
                (healthy == 3'b010) ||
                (healthy == 3'b100);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] a, b, d, maj;
    logic [DATA_W-1:0] lo, hi, pick, v;
    logic [2:0]        e;
    logic              x, m;

    assign a = rep0_i[c*DATA_W +: DATA_W];
    assign b = rep1_i[c*DATA_W +: DATA_W];
    assign d = rep2_i[c*DATA_W +: DATA_W];
    assign maj  = (a & b) | (a & d) | (b & d);
    assign lo   = healthy[0] ? a : b;
    assign hi   = healthy[2] ? d : b;
    assign pick = healthy[0] ? a :
                  healthy[1] ? b : d;

    // Unmasked channels pass rep0 and never blame anyone
    always_comb begin
      v = a;
      e = '0;
      x = 1'b0;
      m = 1'b0;
      if (TMR_MASK[c]) begin
        unique case (1'b1)
          tmr_mode: begin
            v = maj;
            e = {d != maj, b != maj, a != maj};
            x = |e;
          end
          dup_mode: begin
            v = lo;
            m = (lo != hi);
            x = m;
          end
          simp_mode: v = pick;
          default:   v = a;
        endcase
      end
    end

    assign voted_o[c*DATA_W +: DATA_W] = v;
    assign err_ch_o[c] = x;
    assign err0[c]     = e[0];
    assign err1[c]     = e[1];
    assign err2[c]     = e[2];
    assign mis[c]      = m;
  end

  assign rep_err         = {|err2, |err1, |err0};
  assign uncorrectable_o = |mis;

  // Unattributable duplex mismatch: hold every bucket
  for (genvar r = 0; r < 3; r++) begin : g_cnt
    cv32e40p_ft_breakage_counter #(
      .COUNT_BIT         (COUNT_BIT),
      .INC_DEC_BIT       (INC_DEC_BIT),
      .INCREMENT         (INCREMENT),
      .DECREMENT         (DECREMENT),
      .BREAKING_THRESHOLD(BREAKING_THRESHOLD)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en_i),
      .err    (rep_err[r]),
      .clear  (clear_i),
      .freeze (uncorrectable_o),
      .count  (counts_o[r*COUNT_BIT +: COUNT_BIT]),
      .suspect(suspect_o[r]),
      .broken (broken_q[r])
    );
  end

  assign broken_o = broken_q;
  assign fatal_o  = &broken_q;

endmodule

// File: tb/tb_cv32e40p_ft_tmr_monitor.sv
// Directed bench for the TMR monitor: default, masked
// and saturating configurations side by side.
module tb_cv32e40p_ft_tmr_monitor;

  localparam logic [95:0] A =
    {32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
  localparam logic [95:0] E1 =
    {32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5AD};
  localparam logic [95:0] E2 =
    {32'hA5A5A5A5, 32'hA5A5A5A4, 32'hA5A5A5A5};
  localparam logic [95:0] C2_1 =
    {32'h00000001, 32'hA5A5A5A5, 32'hA5A5A5A5};
  localparam logic [95:0] C2_2 =
    {32'h00000002, 32'hA5A5A5A5, 32'hA5A5A5A5};
  localparam logic [95:0] C2_7 =
    {32'h00000007, 32'h0BADF00D, 32'hA5A5A5A5};
  localparam logic [95:0] M1_1 =
    {32'hA5A5A5A5, 32'h00000001, 32'hA5A5A5A5};
  localparam logic [95:0] M1_2 =
    {32'hA5A5A5A5, 32'h00000002, 32'hA5A5A5A5};
  localparam logic [95:0] M1_2E =
    {32'hA5A5A5A5, 32'h00000002, 32'hA5A5A5A4};

  logic clk, rst_n;
  int   checks, failures;

  logic        en, clr;
  logic [95:0] rep0, rep1, rep2, voted;
  logic [2:0]  err_ch, susp, brk;
  logic        unc, fatal;
  logic [23:0] counts;

  logic        m_en, m_clr;
  logic [95:0] m0, m1, m2, m_voted;
  logic [2:0]  m_err, m_susp, m_brk;
  logic        m_unc, m_fatal;
  logic [23:0] m_counts;

  logic        s_en, s_clr;
  logic [95:0] s0, s1, s2, s_voted;
  logic [2:0]  s_err, s_susp, s_brk;
  logic        s_unc, s_fatal;
  logic [5:0]  s_counts;

  cv32e40p_ft_tmr_monitor u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clear_i(clr),
    .rep0_i(rep0), .rep1_i(rep1), .rep2_i(rep2),
    .voted_o(voted), .err_ch_o(err_ch),
    .uncorrectable_o(unc), .suspect_o(susp),
    .broken_o(brk), .fatal_o(fatal), .counts_o(counts)
  );

  cv32e40p_ft_tmr_monitor #(.TMR_MASK(3'b101)) u_mask (
    .clk(clk), .rst_n(rst_n), .en_i(m_en), .clear_i(m_clr),
    .rep0_i(m0), .rep1_i(m1), .rep2_i(m2),
    .voted_o(m_voted), .err_ch_o(m_err),
    .uncorrectable_o(m_unc), .suspect_o(m_susp),
    .broken_o(m_brk), .fatal_o(m_fatal),
    .counts_o(m_counts)
  );

  cv32e40p_ft_tmr_monitor #(
    .INCREMENT(3), .COUNT_BIT(2)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .en_i(s_en), .clear_i(s_clr),
    .rep0_i(s0), .rep1_i(s1), .rep2_i(s2),
    .voted_o(s_voted), .err_ch_o(s_err),
    .uncorrectable_o(s_unc), .suspect_o(s_susp),
    .broken_o(s_brk), .fatal_o(s_fatal),
    .counts_o(s_counts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0;
    rep0 = A; rep1 = A; rep2 = A;
    m_en = 1'b0; m_clr = 1'b0;
    m0 = A; m1 = A; m2 = A;
    s_en = 1'b0; s_clr = 1'b0;
    s0 = A; s1 = A; s2 = A;
    #2;
    chk("rst_counts", counts, 0);
    chk("rst_brk", brk, 0);
    chk("rst_susp", susp, 0);
    chk("rst_fatal", fatal, 0);
    chk("rst_voted", voted, A);
    chk("rst_err", err_ch, 0);
    chk("rst_m_counts", m_counts, 0);
    chk("rst_s_counts", s_counts, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t1_voted", voted, A);
      chk("t1_err", err_ch, 0);
      step();
    end
    chk("t1_counts", counts, 0);

    for (int i = 0; i < 20; i++) begin
      rep2 = (i % 2 == 0) ? E2 : A;
      #1;
      chk("t3_voted", voted, A);
      chk("t3_err", err_ch, (i % 2 == 0) ? 96'd2 : 96'd0);
      step();
      chk("t3_c2", counts[23:16],
          (i % 2 == 0) ? 96'd1 : 96'd0);
      chk("t3_brk", brk, 0);
    end
    rep2 = E2;
    step();
    chk("t3_c2_up", counts[23:16], 1);
    en = 1'b0;
    step();
    step();
    chk("t3_hold_err", counts[23:16], 1);
    rep2 = A;
    step();
    chk("t3_hold_clean", counts[23:16], 1);
    en = 1'b1;
    step();
    chk("t3_c2_down", counts[23:16], 0);

    rep1 = E1;
    #1;
    chk("t2_voted0", voted, A);
    chk("t2_err0", err_ch, 3'b001);
    step();
    chk("t2_c1_e1", counts[15:8], 1);
    chk("t2_susp_e1", susp, 3'b010);
    chk("t2_brk_e1", brk, 0);
    step();
    chk("t2_c1_e2", counts[15:8], 2);
    chk("t2_susp_e2", susp, 3'b010);
    rep0 = C2_1;
    #1;
    chk("t2_voted3", voted, A);
    chk("t2_err3", err_ch, 3'b101);
    step();
    chk("t2_counts_e3", counts, {8'd0, 8'd3, 8'd1});
    chk("t2_brk_e3", brk, 3'b010);
    chk("t2_susp_e3", susp, 3'b001);

    rep2 = C2_2;
    rep1 = C2_7;
    #1;
    chk("t4_unc", unc, 1);
    chk("t4_voted", voted, C2_1);
    chk("t4_err", err_ch, 3'b100);
    step();
    chk("t4_counts", counts, {8'd0, 8'd3, 8'd1});
    chk("t4_fatal", fatal, 0);
    rep0 = A;
    rep2 = A;
    #1;
    chk("t4_agree_unc", unc, 0);
    chk("t4_agree_err", err_ch, 0);
    chk("t4_agree_voted", voted, A);
    step();
    chk("t4_dec", counts, {8'd0, 8'd3, 8'd0});

    clr = 1'b1;
    rep0 = C2_1;
    step();
    chk("t6_clr_counts", counts, 0);
    chk("t6_clr_brk", brk, 0);
    chk("t6_clr_susp", susp, 0);
    rep0 = A;
    rep1 = E1;
    step();
    chk("t6_clr_err_counts", counts, 0);
    clr = 1'b0;
    #1;
    chk("t6_tmr_err", err_ch, 3'b001);
    step();
    chk("t6_c1", counts[15:8], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_counts", counts, 0);
    chk("t6_arst_susp", susp, 0);
    chk("t6_arst_brk", brk, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rep1 = A;

    m_en = 1'b1;
    m0 = M1_1; m1 = M1_1; m2 = M1_2;
    #1;
    chk("t5_voted_a", m_voted, M1_1);
    chk("t5_err_a", m_err, 0);
    step();
    chk("t5_counts_a", m_counts, 0);
    m1 = M1_2;
    #1;
    chk("t5_voted_b", m_voted, M1_1);
    chk("t5_err_b", m_err, 0);
    step();
    chk("t5_counts_b", m_counts, 0);
    m1 = M1_1;
    m2 = M1_2E;
    #1;
    chk("t5_err_c", m_err, 3'b001);
    step();
    chk("t5_counts_c", m_counts, {8'd1, 8'd0, 8'd0});

    s_en = 1'b1;
    s2 = E2;
    step();
    chk("t6_sat_counts", s_counts, 6'b110000);
    chk("t6_sat_brk", s_brk, 3'b100);
    step();
    chk("t6_sat_hold", s_counts, 6'b110000);
    chk("t6_sat_fatal", s_fatal, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
